// File: rtl/mem_sync_arbiter_if.sv
// Bundle between the MEMSync bank array, the row-transfer arbiter and the
// backing-memory / row-buffer ports.
interface mem_sync_arbiter_if #(
    parameter int unsigned NBANKS    = 4,
    parameter int unsigned CHWIDTH   = 6,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned BEATS     = 8
);
    localparam int unsigned BANKW = $clog2(NBANKS);
    localparam int unsigned BEATW = $clog2(BEATS);

    logic [NBANKS-1:0]             req_valid;
    logic [NBANKS-1:0]             req_wb;
    logic [NBANKS*ADDRWIDTH-1:0]   req_rowid;
    logic [NBANKS*CHWIDTH-1:0]     req_crow;
    logic [NBANKS-1:0]             sync;
    logic                          busy;
    logic [BANKW-1:0]              gnt_bank;
    logic                          mem_req;
    logic                          mem_we;
    logic [ADDRWIDTH+BEATW-1:0]    mem_addr;
    logic                          mem_ack;
    logic                          buf_en;
    logic                          buf_we;
    logic [BANKW+CHWIDTH+BEATW-1:0] buf_addr;

    // Arbiter side
    modport master (
        input  req_valid, req_wb, req_rowid, req_crow, mem_ack,
        output sync, busy, gnt_bank, mem_req, mem_we, mem_addr,
               buf_en, buf_we, buf_addr
    );

    // Bank array / memory model side
    modport slave (
        output req_valid, req_wb, req_rowid, req_crow, mem_ack,
        input  sync, busy, gnt_bank, mem_req, mem_we, mem_addr,
               buf_en, buf_we, buf_addr
    );
endinterface

// File: rtl/mem_sync_arbiter.sv
// Round-robin arbiter sharing one backing-memory row-transfer channel between
// MEMSync banks; moves BEATS words per grant and pulses the bank's sync.
module mem_sync_arbiter #(
    parameter int unsigned NBANKS    = 4,
    parameter int unsigned CHWIDTH   = 6,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned BEATS     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_sync_arbiter_if.master bus
);
    localparam int unsigned BANKW = $clog2(NBANKS);
    localparam int unsigned BEATW = $clog2(BEATS);
    localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(BEATS - 1);
    localparam logic [BANKW-1:0] LAST_BANK = BANKW'(NBANKS - 1);

    typedef enum logic [1:0] {IDLE, RDBUF, XFER, DONE} state_t;

    state_t                 state, state_nxt;
    logic [BANKW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [BANKW-1:0]       gnt_q, gnt_nxt;
    logic [BEATW-1:0]       beat, beat_nxt;
    logic                   wb_q, wb_nxt;
    logic [ADDRWIDTH-1:0]   rowid_q, rowid_nxt;
    logic [CHWIDTH-1:0]     crow_q, crow_nxt;

    logic                   found;
    logic [BANKW-1:0]       pick;
    logic [BANKW-1:0]       idx;
    logic                   sel_wb;
    logic [ADDRWIDTH-1:0]   sel_rowid;
    logic [CHWIDTH-1:0]     sel_crow;

    logic [NBANKS-1:0]      sync_c;
    logic                   mem_req_c;
    logic                   mem_we_c;
    logic                   buf_en_c;
    logic                   buf_we_c;

    // First requesting bank at or above rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        idx   = rr_ptr;
        for (int unsigned i = 0; i < NBANKS; i++) begin
            idx = BANKW'((32'(rr_ptr) + i) % NBANKS);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Request fields of the candidate bank
    always_comb begin
        sel_wb    = 1'b0;
        sel_rowid = '0;
        sel_crow  = '0;
        for (int unsigned b = 0; b < NBANKS; b++) begin
            if (pick == BANKW'(b)) begin
                sel_wb    = bus.req_wb[b];
                sel_rowid = bus.req_rowid[b*ADDRWIDTH +: ADDRWIDTH];
                sel_crow  = bus.req_crow[b*CHWIDTH +: CHWIDTH];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gnt_nxt    = gnt_q;
        beat_nxt   = beat;
        wb_nxt     = wb_q;
        rowid_nxt  = rowid_q;
        crow_nxt   = crow_q;
        sync_c     = '0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        buf_en_c   = 1'b0;
        buf_we_c   = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    wb_nxt    = sel_wb;
                    rowid_nxt = sel_rowid;
                    crow_nxt  = sel_crow;
                    beat_nxt  = '0;
                    state_nxt = sel_wb ? RDBUF : XFER;
                end
            end
            RDBUF: begin
                // Buffer word appears next cycle on the memory write data path
                buf_en_c  = 1'b1;
                state_nxt = XFER;
            end
            XFER: begin
                mem_req_c = 1'b1;
                mem_we_c  = wb_q;
                if (!wb_q) begin
                    buf_en_c = bus.mem_ack;
                    buf_we_c = bus.mem_ack;
                end
                if (bus.mem_ack) begin
                    if (beat == LAST_BEAT) begin
                        state_nxt = DONE;
                    end else begin
                        beat_nxt  = beat + BEATW'(1);
                        state_nxt = wb_q ? RDBUF : XFER;
                    end
                end
            end
            DONE: begin
                sync_c     = NBANKS'(1) << gnt_q;
                rr_ptr_nxt = (gnt_q == LAST_BANK) ? '0 : gnt_q + BANKW'(1);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_q   <= '0;
            beat    <= '0;
            wb_q    <= 1'b0;
            rowid_q <= '0;
            crow_q  <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            gnt_q   <= gnt_nxt;
            beat    <= beat_nxt;
            wb_q    <= wb_nxt;
            rowid_q <= rowid_nxt;
            crow_q  <= crow_nxt;
        end
    end

    assign bus.sync     = sync_c;
    assign bus.busy     = (state != IDLE);
    assign bus.gnt_bank = gnt_q;
    assign bus.mem_req  = mem_req_c;
    assign bus.mem_we   = mem_we_c;
    assign bus.mem_addr = {rowid_q, beat};
    assign bus.buf_en   = buf_en_c;
    assign bus.buf_we   = buf_we_c;
    assign bus.buf_addr = {gnt_q, crow_q, beat};

endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Self-checking bench for mem_sync_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-queue reference model.
module tb_mem_sync_arbiter;
    localparam int unsigned NB = 4;
    localparam int unsigned CW = 6;
    localparam int unsigned AW = 17;
    localparam int unsigned BT = 8;

    localparam int K_RD   = 0;
    localparam int K_MEM  = 1;
    localparam int K_SYNC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_sync_arbiter_if #(.NBANKS(NB), .CHWIDTH(CW), .ADDRWIDTH(AW), .BEATS(BT)) bus ();

    mem_sync_arbiter #(.NBANKS(NB), .CHWIDTH(CW), .ADDRWIDTH(AW), .BEATS(BT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remaining cycle-events of the current transfer
    typedef struct {
        int kind;
        int beat;
    } item_t;

    item_t          mq[$];
    int             m_rr   = 0;
    int             m_bank = 0;
    bit             m_wb   = 1'b0;
    logic [AW-1:0]  m_row  = '0;
    logic [CW-1:0]  m_crow = '0;

    int             cyc      = 0;
    int             sync_cyc = -1;
    logic [NB-1:0]  sync_val = '0;
    int             acks     = 0;
    int             syncs[NB];
    int             glog[$];
    bit             prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant(input int b);
        m_bank = b;
        m_wb   = bus.req_wb[b];
        m_row  = bus.req_rowid[b*AW +: AW];
        m_crow = bus.req_crow[b*CW +: CW];
        for (int k = 0; k < BT; k++) begin
            if (m_wb) mq.push_back('{K_RD, k});
            mq.push_back('{K_MEM, k});
        end
        mq.push_back('{K_SYNC, 0});
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            mq.delete();
            m_rr   = 0;
            m_bank = 0;
            m_wb   = 1'b0;
            m_row  = '0;
            m_crow = '0;
        end else if (mq.size() == 0) begin
            for (int i = 0; i < NB; i++) begin
                int b;
                b = (m_rr + i) % NB;
                if (bus.req_valid[b]) begin
                    model_grant(b);
                    break;
                end
            end
        end else if (!(mq[0].kind == K_MEM && !bus.mem_ack)) begin
            if (mq[0].kind == K_SYNC) m_rr = (m_bank + 1) % NB;
            void'(mq.pop_front());
        end
    endtask

    task automatic check_outputs();
        bit            f_rd, f_mem, f_sync, alloc_wr;
        int            fb;
        logic [NB-1:0] e_sync;
        f_rd = 1'b0; f_mem = 1'b0; f_sync = 1'b0; fb = 0;
        if (mq.size() > 0) begin
            f_rd   = (mq[0].kind == K_RD);
            f_mem  = (mq[0].kind == K_MEM);
            f_sync = (mq[0].kind == K_SYNC);
            fb     = mq[0].beat;
        end
        alloc_wr = f_mem && !m_wb && bus.mem_ack;
        e_sync   = f_sync ? (4'(1) << m_bank) : 4'(0);
        chk("busy",     32'(bus.busy),     32'(mq.size() != 0));
        chk("sync",     32'(bus.sync),     32'(e_sync));
        chk("mem_req",  32'(bus.mem_req),  32'(f_mem));
        chk("mem_we",   32'(bus.mem_we),   32'(f_mem && m_wb));
        chk("buf_en",   32'(bus.buf_en),   32'(f_rd || alloc_wr));
        chk("buf_we",   32'(bus.buf_we),   32'(alloc_wr));
        chk("gnt_bank", 32'(bus.gnt_bank), 32'(m_bank));
        if (f_mem) chk("mem_addr", 32'(bus.mem_addr), 32'({m_row, 3'(fb)}));
        if (f_rd || alloc_wr) chk("buf_addr", 32'(bus.buf_addr), 32'({2'(m_bank), m_crow, 3'(fb)}));

        if (bus.sync != '0) begin
            sync_cyc = cyc;
            sync_val = bus.sync;
            for (int b = 0; b < NB; b++) if (bus.sync[b]) syncs[b]++;
        end
        if (bus.mem_req && bus.mem_ack) acks++;
        if (bus.busy && !prev_busy) glog.push_back(int'(bus.gnt_bank));
        prev_busy = bus.busy;
    endtask

    // One clock: check at the falling edge, then advance the model across the rising edge
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_bank(input int b, input bit v, input bit wb,
                            input logic [AW-1:0] row, input logic [CW-1:0] cr);
        bus.req_valid[b]          = v;
        bus.req_wb[b]             = wb;
        bus.req_rowid[b*AW +: AW] = row;
        bus.req_crow[b*CW +: CW]  = cr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n;
        n = 0;
        while ((bus.busy || mq.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk(tag, 32'(n < maxc), 32'd1);
    endtask

    task automatic wait_grants(input int target, input int maxc, input string tag);
        int n;
        n = 0;
        while (glog.size() < target && n < maxc) begin
            step();
            n++;
        end
        chk(tag, 32'(glog.size() >= target), 32'd1);
    endtask

    initial begin
        int t0, n0, a0, s0, stall;
        for (int b = 0; b < NB; b++) syncs[b] = 0;
        bus.req_valid = '0;
        bus.req_wb    = '0;
        bus.req_rowid = '0;
        bus.req_crow  = '0;
        bus.mem_ack   = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_sync",     32'(bus.sync),     32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        rst_n = 1'b1;

        // Single allocate on bank 2
        bus.mem_ack = 1'b1;
        set_bank(2, 1'b1, 1'b0, 17'h1A5, 6'd3);
        t0 = cyc;
        step();
        set_bank(2, 1'b0, 1'b0, 17'h1A5, 6'd3);
        chk("t1_addr0",    32'(bus.mem_addr), 32'h0000_0D28);
        chk("t1_bufaddr0", 32'(bus.buf_addr), 32'h0000_0418);
        repeat (10) step();
        chk("t1_latency", 32'(sync_cyc - t0), 32'd9);
        chk("t1_syncval", 32'(sync_val),      32'b0100);

        // Single writeback on bank 0
        set_bank(0, 1'b1, 1'b1, 17'($urandom), 6'($urandom));
        t0 = cyc;
        step();
        bus.req_valid[0] = 1'b0;
        repeat (18) step();
        chk("t2_latency", 32'(sync_cyc - t0), 32'd17);
        chk("t2_syncval", 32'(sync_val),      32'b0001);

        // All four banks from reset, then banks 0 and 3
        do_reset();
        n0 = glog.size();
        for (int b = 0; b < NB; b++) set_bank(b, 1'b1, 1'($urandom), 17'($urandom), 6'($urandom));
        wait_grants(n0 + 4, 200, "t3_grants_bound");
        bus.req_valid = '0;
        wait_idle(100, "t3_idle_bound");
        for (int i = 0; i < 4; i++) chk("t3_order", 32'(glog[n0+i]), 32'(i));

        do_reset();
        n0 = glog.size();
        set_bank(0, 1'b1, 1'b0, 17'($urandom), 6'($urandom));
        set_bank(3, 1'b1, 1'b1, 17'($urandom), 6'($urandom));
        wait_grants(n0 + 2, 100, "t3b_grants_bound");
        bus.req_valid = '0;
        wait_idle(100, "t3b_idle_bound");
        chk("t3b_first",  32'(glog[n0]),   32'd0);
        chk("t3b_second", 32'(glog[n0+1]), 32'd3);

        // Bank 1 writeback then allocate with stall held; bank 2 goes in between
        do_reset();
        n0 = glog.size();
        s0 = syncs[1];
        set_bank(1, 1'b1, 1'b1, 17'($urandom), 6'($urandom));
        wait_grants(n0 + 1, 20, "t4_first_bound");
        set_bank(2, 1'b1, 1'b0, 17'($urandom), 6'($urandom));
        for (int n = 0; n < 200 && glog.size() < n0 + 3; n++) begin
            step();
            if (syncs[1] == s0 + 1 && bus.req_wb[1]) bus.req_wb[1] = 1'b0;
            if (glog.size() >= n0 + 2) bus.req_valid[2] = 1'b0;
        end
        bus.req_valid = '0;
        wait_idle(100, "t4_idle_bound");
        chk("t4_grants", 32'(glog.size() - n0), 32'd3);
        chk("t4_g0", 32'(glog[n0]),   32'd1);
        chk("t4_g1", 32'(glog[n0+1]), 32'd2);
        chk("t4_g2", 32'(glog[n0+2]), 32'd1);
        chk("t4_syncs_b1", 32'(syncs[1] - s0), 32'd2);

        // mem_ack withheld for five cycles on beat 3
        do_reset();
        s0    = syncs[3];
        a0    = acks;
        stall = 0;
        bus.mem_ack = 1'b1;
        set_bank(3, 1'b1, 1'b0, 17'($urandom), 6'($urandom));
        t0 = cyc;
        step();
        bus.req_valid[3] = 1'b0;
        for (int n = 0; n < 40 && syncs[3] == s0; n++) begin
            if (bus.mem_req && bus.mem_addr[2:0] == 3'd3 && stall < 5) begin
                bus.mem_ack = 1'b0;
                stall++;
            end else begin
                bus.mem_ack = 1'b1;
            end
            step();
        end
        bus.mem_ack = 1'b1;
        chk("t5_stalls",  32'(stall),         32'd5);
        chk("t5_acks",    32'(acks - a0),     32'd8);
        chk("t5_latency", 32'(sync_cyc - t0), 32'd14);

        // Reset during beat 4 of a writeback
        do_reset();
        set_bank(0, 1'b1, 1'b1, 17'($urandom), 6'($urandom));
        for (int n = 0; n < 40 && !(bus.mem_req && bus.mem_addr[2:0] == 3'd4); n++) step();
        chk("t6_reach_beat4", 32'(bus.mem_req && bus.mem_addr[2:0] == 3'd4), 32'd1);
        s0 = syncs[0];
        rst_n = 1'b0;
        step();
        chk("t6_busy",     32'(bus.busy),     32'd0);
        chk("t6_sync",     32'(bus.sync),     32'd0);
        chk("t6_mem_req",  32'(bus.mem_req),  32'd0);
        chk("t6_buf_en",   32'(bus.buf_en),   32'd0);
        chk("t6_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("t6_buf_addr", 32'(bus.buf_addr), 32'd0);
        chk("t6_gnt",      32'(bus.gnt_bank), 32'd0);
        rst_n = 1'b1;
        n0 = glog.size();
        wait_grants(n0 + 1, 20, "t6_regrant_bound");
        chk("t6_regrant_bank", 32'(glog[n0]),           32'd0);
        chk("t6_restart_beat", 32'(bus.mem_addr[2:0]),  32'd0);
        bus.req_valid = '0;
        wait_idle(100, "t6_idle_bound");
        chk("t6_one_sync", 32'(syncs[0] - s0), 32'd1);

        // Random traffic, random acks and occasional resets
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = 4'($urandom);
            bus.req_wb    = 4'($urandom);
            bus.req_rowid = 68'({$urandom, $urandom, $urandom});
            bus.req_crow  = 24'($urandom);
            bus.mem_ack   = ($urandom_range(0, 9) < 7);
            rst_n         = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.mem_ack   = 1'b1;
        wait_idle(100, "rand_drain_bound");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
